// File: rtl/enable_pulse_scheduler.sv
// enable_pulse_scheduler: queues single-cycle events and issues them one at a time
// as enable pulses to a toggle crossing, waiting for each ack (with a watchdog).
module enable_pulse_scheduler #(
    parameter int PENDING_WIDTH  = 4,
    parameter int DROP_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     event_in,
    output logic                     enable_out,
    input  logic                     ack_in,
    input  logic                     clear_flags,
    output logic                     busy,
    output logic [PENDING_WIDTH-1:0] pending_count,
    output logic [DROP_WIDTH-1:0]    dropped_count,
    output logic                     timeout_flag
);
    localparam int WD_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                   r_state, w_state_nxt;
    logic [WD_W-1:0]          r_wd, w_wd_nxt;
    logic [PENDING_WIDTH-1:0] r_pend, w_pend_nxt;
    logic [DROP_WIDTH-1:0]    r_drop, w_drop_base, w_drop_nxt;
    logic                     r_flag, w_flag_nxt;
    logic                     r_en, w_issue, w_ack, w_timeout, w_dec, w_full, w_inc, w_drop;

    always_comb begin
        w_state_nxt = r_state;
        w_wd_nxt    = r_wd;
        w_issue     = 1'b0;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        if (r_state == IDLE) begin
            if (r_pend != '0) begin
                w_issue     = 1'b1;
                w_state_nxt = WAIT;
                w_wd_nxt    = '0;
            end
        end else begin
            // An ack in the firing cycle wins over the watchdog.
            w_ack       = ack_in;
            w_timeout   = (TIMEOUT_CYCLES != 0) && !ack_in && (r_wd == WD_LAST);
            w_wd_nxt    = r_wd + 1'b1;
            w_state_nxt = (w_ack || w_timeout) ? IDLE : WAIT;
        end
        w_dec       = w_ack || w_timeout;
        w_full      = &r_pend;
        w_inc       = event_in && (!w_full || w_dec);
        w_drop      = event_in && w_full && !w_dec;
        w_pend_nxt  = (w_inc && !w_dec) ? r_pend + 1'b1 :
                      (w_dec && !w_inc) ? r_pend - 1'b1 : r_pend;
        // Clear first, so a same-cycle drop or timeout still registers.
        w_drop_base = clear_flags ? '0 : r_drop;
        w_drop_nxt  = (w_drop && !(&w_drop_base)) ? w_drop_base + 1'b1 : w_drop_base;
        w_flag_nxt  = (r_flag && !clear_flags) || w_timeout;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_wd    <= '0;
            r_pend  <= '0;
            r_drop  <= '0;
            r_flag  <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wd    <= w_wd_nxt;
            r_pend  <= w_pend_nxt;
            r_drop  <= w_drop_nxt;
            r_flag  <= w_flag_nxt;
            r_en    <= w_issue;
        end
    end

    assign enable_out    = r_en;
    assign busy          = (r_state == WAIT);
    assign pending_count = r_pend;
    assign dropped_count = r_drop;
    assign timeout_flag  = r_flag;
endmodule

// File: tb/tb_enable_pulse_scheduler.sv
// tb_enable_pulse_scheduler: directed checks of the scheduler; a second instance
// with the watchdog disabled shares the stimulus for the saturation scenario.
module tb_enable_pulse_scheduler;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       event_in = 1'b0;
    logic       ack_in = 1'b0;
    logic       clear_flags = 1'b0;
    logic       en, busy, flag;
    logic [3:0] pend;
    logic [7:0] drop;
    logic       en0, busy0, flag0;
    logic [3:0] pend0;
    logic [7:0] drop0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         pulses0;

    enable_pulse_scheduler #(.PENDING_WIDTH(4), .DROP_WIDTH(8), .TIMEOUT_CYCLES(64)) dut (
        .clock(clock), .reset_n(reset_n), .event_in(event_in), .enable_out(en),
        .ack_in(ack_in), .clear_flags(clear_flags), .busy(busy),
        .pending_count(pend), .dropped_count(drop), .timeout_flag(flag)
    );

    enable_pulse_scheduler #(.PENDING_WIDTH(4), .DROP_WIDTH(8), .TIMEOUT_CYCLES(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .event_in(event_in), .enable_out(en0),
        .ack_in(ack_in), .clear_flags(clear_flags), .busy(busy0),
        .pending_count(pend0), .dropped_count(drop0), .timeout_flag(flag0)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input logic ev, input logic ak, input logic cl);
        event_in    = ev;
        ack_in      = ak;
        clear_flags = cl;
        @(posedge clock);
        #1;
    endtask

    task automatic all_zero(input string tag);
        check({tag, " en"}, int'(en), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " pend"}, int'(pend), 0);
        check({tag, " drop"}, int'(drop), 0);
        check({tag, " flag"}, int'(flag), 0);
        check({tag, " en0"}, int'(en0), 0);
        check({tag, " busy0"}, int'(busy0), 0);
        check({tag, " pend0"}, int'(pend0), 0);
        check({tag, " drop0"}, int'(drop0), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        event_in = 1'b0;
        ack_in = 1'b0;
        clear_flags = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        all_zero("reset");
    endtask

    initial begin
        do_reset();
        // Single event, ack 5 cycles after the pulse, then stray acks while idle.
        for (int c = 0; c < 12; c++) begin
            check($sformatf("single en c%0d", c), int'(en), int'(c == 2));
            check($sformatf("single busy c%0d", c), int'(busy), int'(c >= 2 && c <= 7));
            check($sformatf("single pend c%0d", c), int'(pend), int'(c >= 1 && c <= 7));
            cyc(c == 0, c == 7 || c == 9 || c == 10, 1'b0);
        end
        check("stray drop", int'(drop), 0);
        check("stray flag", int'(flag), 0);

        // Burst to saturation, then watchdog on vs disabled, then event+ack while full.
        do_reset();
        pulses0 = 0;
        for (int c = 0; c < 100; c++) begin
            if (en0) pulses0++;
            if (c == 20) begin
                check("burst pend0", int'(pend0), 15);
                check("burst drop0", int'(drop0), 5);
                check("burst pend", int'(pend), 15);
                check("burst drop", int'(drop), 5);
            end
            if (c == 21) begin
                check("clear+drop drop0", int'(drop0), 1);
                check("clear+drop drop", int'(drop), 1);
            end
            cyc(c <= 20, 1'b0, c == 20);
        end
        check("burst pulses0", pulses0, 1);
        check("no wd pend0", int'(pend0), 15);
        check("no wd flag0", int'(flag0), 0);
        check("wd pend", int'(pend), 14);
        check("wd flag", int'(flag), 1);
        cyc(1'b1, 1'b1, 1'b0);
        check("full ev+ack pend0", int'(pend0), 15);
        check("full ev+ack drop0", int'(drop0), 1);
        check("full ev+ack busy0", int'(busy0), 0);
        check("ev+ack pend", int'(pend), 14);
        check("ev+ack busy", int'(busy), 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("reissue en0", int'(en0), 1);
        check("reissue en", int'(en), 1);
        check("reissue busy", int'(busy), 1);

        // Asynchronous reset between edges while a pulse is out.
        #2 reset_n = 1'b0;
        #1 all_zero("async");
        check("async flag0", int'(flag0), 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        all_zero("late ack");
        cyc(1'b1, 1'b0, 1'b0);
        check("post pend", int'(pend), 1);
        check("post en early", int'(en), 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("post en", int'(en), 1);
        check("post busy", int'(busy), 1);

        // Watchdog: two events, timeouts, clear vs timeout race, ack on the firing cycle.
        do_reset();
        for (int c = 0; c < 200; c++) begin
            if (c == 2) begin
                check("wd first en", int'(en), 1);
                check("wd first pend", int'(pend), 2);
            end
            if (c == 65) begin
                check("wd pre flag", int'(flag), 0);
                check("wd pre pend", int'(pend), 2);
                check("wd pre busy", int'(busy), 1);
            end
            if (c == 66) begin
                check("wd fire flag", int'(flag), 1);
                check("wd fire pend", int'(pend), 1);
                check("wd fire busy", int'(busy), 0);
                check("wd fire en", int'(en), 0);
            end
            if (c == 67) check("wd second en", int'(en), 1);
            if (c == 70) check("wd clear flag", int'(flag), 0);
            if (c == 131) begin
                check("clear+timeout flag", int'(flag), 1);
                check("clear+timeout pend", int'(pend), 0);
            end
            if (c == 132) check("wd clear2 flag", int'(flag), 0);
            if (c == 134) check("prio en", int'(en), 1);
            if (c == 197) check("prio busy", int'(busy), 1);
            if (c == 198) begin
                check("prio pend", int'(pend), 0);
                check("prio flag", int'(flag), 0);
                check("prio busy after", int'(busy), 0);
            end
            cyc(c < 2 || c == 132, c == 197, c == 69 || c == 130 || c == 131);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
